// File: rtl/hpu_ren_fl_nw.sv
// hpu_ren_fl_nw: N-wide physical-register free list for the rename stage.
//
// Hands out up to ALLOC_W distinct free physical indices per cycle and takes up to FREE_W
// releases from ROB retire. It holds CKPT_DEPTH branch checkpoint images and can restore
// the free list from a checkpoint or from the architectural free list. It also reports a
// stall condition and a registered free count. Physical index 0 is reserved: it is always
// free and is never allocated.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   alloc_act_i      per-slot allocate request
//   arc_rdst_i       per-slot architectural destination (0 = no destination)
//   phy_rdst_o       per-slot allocated physical index (combinational)
//   free_en_i        per-slot release valid
//   free_idx_i       per-slot released physical index
//   ckpt_save_en_i   save the current free list into checkpoint ckpt_save_idx_i
//   ckpt_rcov_en_i   restore the free list from checkpoint ckpt_rcov_idx_i
//   afl_rcov_en_i    restore the free list from afl_rcov_data_i (highest priority)
//   safe_mode_i      stall on the registered count instead of the candidate count
//   fl_stall_o       not enough free entries
//   fl_cnt_o         registered free-entry count, excluding index 0
//   fl_dbl_free_o    sticky double-free error flag
//
// Optional feature: define HPU_FL_DBL_FREE_CHK_EN to build the double-free checker.
// Without it, fl_dbl_free_o is tied to 0.

module hpu_ren_fl_nw #(
    parameter int unsigned PHY_LEN      = 64,
    parameter int unsigned ALLOC_W      = 2,
    parameter int unsigned FREE_W       = 2,
    parameter int unsigned CKPT_DEPTH   = 4,
    parameter int unsigned ARC_IDX_W    = 5,
    parameter int unsigned STALL_THRESH = 2 * ALLOC_W + 2,
    localparam int unsigned PIDX_W      = $clog2(PHY_LEN),
    localparam int unsigned CIDX_W      = $clog2(CKPT_DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [ALLOC_W-1:0]            alloc_act_i,
    input  logic [ALLOC_W*ARC_IDX_W-1:0]  arc_rdst_i,
    output logic [ALLOC_W*PIDX_W-1:0]     phy_rdst_o,
    input  logic [FREE_W-1:0]             free_en_i,
    input  logic [FREE_W*PIDX_W-1:0]      free_idx_i,
    input  logic                          ckpt_save_en_i,
    input  logic [CIDX_W-1:0]             ckpt_save_idx_i,
    input  logic                          ckpt_rcov_en_i,
    input  logic [CIDX_W-1:0]             ckpt_rcov_idx_i,
    input  logic                          afl_rcov_en_i,
    input  logic [PHY_LEN-1:0]            afl_rcov_data_i,
    input  logic                          safe_mode_i,
    output logic                          fl_stall_o,
    output logic [PIDX_W:0]               fl_cnt_o,
    output logic                          fl_dbl_free_o
);

    localparam int unsigned CNT_W = PIDX_W + 1;
    localparam int unsigned AV_W  = $clog2(ALLOC_W + 1);

    logic [PHY_LEN-1:0] r_fl;
    logic [PHY_LEN-1:0] r_ckpt [CKPT_DEPTH];
    logic [CNT_W-1:0]   r_cnt;

    logic [PHY_LEN-1:0] w_fl_d;
    logic [PHY_LEN-1:0] w_rel;
    logic [PHY_LEN-1:0] w_clr;
    logic [CNT_W-1:0]   w_pop;
    logic [PIDX_W-1:0]  w_cand [ALLOC_W];
    logic [AV_W-1:0]    w_avail;
    logic               w_stall;

    // cand[k] is the k-th lowest free index above 0; missing candidates read as 0.
    always_comb begin
        logic [AV_W-1:0] v_found;
        v_found = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            w_cand[k] = '0;
        end
        for (int j = 1; j < PHY_LEN; j++) begin
            if (r_fl[j]) begin
                for (int k = 0; k < ALLOC_W; k++) begin
                    if (v_found == AV_W'(k)) begin
                        w_cand[k] = PIDX_W'(j);
                    end
                end
                if (v_found < AV_W'(ALLOC_W)) begin
                    v_found = v_found + 1'b1;
                end
            end
        end
        w_avail = v_found;
    end

    always_comb begin
        logic [CNT_W-1:0] v_pop;
        v_pop = '0;
        for (int j = 1; j < PHY_LEN; j++) begin
            v_pop = v_pop + CNT_W'(r_fl[j]);
        end
        w_pop = v_pop;
    end

    assign w_stall    = safe_mode_i ? (r_cnt < CNT_W'(STALL_THRESH))
                                    : (w_avail < AV_W'(ALLOC_W));
    assign fl_stall_o = w_stall;
    assign fl_cnt_o   = r_cnt;

    // Each slot is tied to its own candidate position; idle slots do not shift later ones.
    always_comb begin
        phy_rdst_o = '0;
        w_clr      = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (arc_rdst_i[i*ARC_IDX_W +: ARC_IDX_W] != '0) begin
                phy_rdst_o[i*PIDX_W +: PIDX_W] = w_cand[i];
                if (alloc_act_i[i] && !w_stall) begin
                    w_clr[w_cand[i]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rel = '0;
        for (int f = 0; f < FREE_W; f++) begin
            if (free_en_i[f] && (free_idx_i[f*PIDX_W +: PIDX_W] != '0)) begin
                w_rel[free_idx_i[f*PIDX_W +: PIDX_W]] = 1'b1;
            end
        end
    end

    // Releases are applied after allocation clears, so a release wins on a shared index.
    always_comb begin
        if (afl_rcov_en_i) begin
            w_fl_d = afl_rcov_data_i;
        end else if (ckpt_rcov_en_i) begin
            w_fl_d = r_ckpt[ckpt_rcov_idx_i] | w_rel;
        end else begin
            w_fl_d = (r_fl & ~w_clr) | w_rel;
        end
        w_fl_d[0] = 1'b1;
    end

    // Releases refresh every checkpoint image; restore reads the old image of a slot being saved.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fl  <= '1;
            r_cnt <= CNT_W'(PHY_LEN - 1);
            for (int c = 0; c < CKPT_DEPTH; c++) begin
                r_ckpt[c] <= '0;
            end
        end else begin
            r_fl  <= w_fl_d;
            r_cnt <= w_pop;
            for (int c = 0; c < CKPT_DEPTH; c++) begin
                if (ckpt_save_en_i && (ckpt_save_idx_i == CIDX_W'(c))) begin
                    r_ckpt[c] <= r_fl | w_rel;
                end else begin
                    r_ckpt[c] <= r_ckpt[c] | w_rel;
                end
            end
        end
    end

`ifdef HPU_FL_DBL_FREE_CHK_EN
    logic r_dbl;
    logic w_dbl;

    // Flags a release of an already-free index, or two slots releasing the same index.
    always_comb begin
        w_dbl = 1'b0;
        for (int f = 0; f < FREE_W; f++) begin
            if (free_en_i[f] && (free_idx_i[f*PIDX_W +: PIDX_W] != '0)) begin
                if (r_fl[free_idx_i[f*PIDX_W +: PIDX_W]]) begin
                    w_dbl = 1'b1;
                end
                for (int g = f + 1; g < FREE_W; g++) begin
                    if (free_en_i[g] &&
                        (free_idx_i[g*PIDX_W +: PIDX_W] == free_idx_i[f*PIDX_W +: PIDX_W])) begin
                        w_dbl = 1'b1;
                    end
                end
            end
        end
        if (afl_rcov_en_i || ckpt_rcov_en_i) begin
            w_dbl = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dbl <= 1'b0;
        end else if (w_dbl) begin
            r_dbl <= 1'b1;
        end
    end

    assign fl_dbl_free_o = r_dbl;
`else
    assign fl_dbl_free_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpu_ren_fl_nw.sv
// tb_hpu_ren_fl_nw: self-checking bench for hpu_ren_fl_nw at default parameters.
// A table of single-cycle vectors is followed by hand-written multi-cycle sequences
// for fill/stall, checkpoints, architectural restore and the double-free flag.
// Expected results go into a scoreboard queue when stimulus is driven and are popped
// when the outputs are sampled.

module tb_hpu_ren_fl_nw;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  alloc_act;
    logic [9:0]  arc_rdst;
    logic [11:0] phy_rdst;
    logic [1:0]  free_en;
    logic [11:0] free_idx;
    logic        save_en;
    logic [1:0]  save_idx;
    logic        rcov_en;
    logic [1:0]  rcov_idx;
    logic        afl_en;
    logic [63:0] afl_data;
    logic        safe;
    logic        stall;
    logic [6:0]  cnt;
    logic        dbl;

    always #5 clk = ~clk;

    hpu_ren_fl_nw dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .alloc_act_i     (alloc_act),
        .arc_rdst_i      (arc_rdst),
        .phy_rdst_o      (phy_rdst),
        .free_en_i       (free_en),
        .free_idx_i      (free_idx),
        .ckpt_save_en_i  (save_en),
        .ckpt_save_idx_i (save_idx),
        .ckpt_rcov_en_i  (rcov_en),
        .ckpt_rcov_idx_i (rcov_idx),
        .afl_rcov_en_i   (afl_en),
        .afl_rcov_data_i (afl_data),
        .safe_mode_i     (safe),
        .fl_stall_o      (stall),
        .fl_cnt_o        (cnt),
        .fl_dbl_free_o   (dbl)
    );

    typedef struct {
        logic [1:0] act;
        int         arc0, arc1;
        logic [1:0] fen;
        int         f0, f1;
        int         p0, p1, st, cn;
    } vec_t;

    typedef struct {
        string name;
        int    p0, p1, st, cn, dbl;
    } exp_t;

`ifdef HPU_FL_DBL_FREE_CHK_EN
    localparam int DblOn = 1;
`else
    localparam int DblOn = 0;
`endif

    exp_t sb[$];
    vec_t vec [13];
    int   n_run = 0;
    int   n_fail = 0;
    int   g_dbl_exp;

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        alloc_act = '0; arc_rdst = '0; free_en = '0; free_idx = '0;
        save_en = 1'b0; save_idx = '0; rcov_en = 1'b0; rcov_idx = '0;
        afl_en = 1'b0; afl_data = '0; safe = 1'b0;
    endtask

    task automatic set_alloc(input logic [1:0] act, input int a0, input int a1);
        alloc_act = act;
        arc_rdst  = {5'(a1), 5'(a0)};
    endtask

    task automatic set_free(input logic [1:0] en, input int f0, input int f1);
        free_en  = en;
        free_idx = {6'(f1), 6'(f0)};
    endtask

    // Called just after a negedge with inputs already driven; cn/dbl < 0 means unchecked.
    task automatic step(input string nm, input int p0, input int p1, input int st, input int cn);
        exp_t e;
        e.name = nm; e.p0 = p0; e.p1 = p1; e.st = st; e.cn = cn; e.dbl = g_dbl_exp;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk({e.name, ".p0"}, int'(phy_rdst[5:0]), e.p0);
        chk({e.name, ".p1"}, int'(phy_rdst[11:6]), e.p1);
        chk({e.name, ".stall"}, int'(stall), e.st);
        if (e.cn >= 0) chk({e.name, ".cnt"}, int'(cnt), e.cn);
        if (e.dbl >= 0) chk({e.name, ".dbl"}, int'(dbl), e.dbl);
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    // Reset is held while other inputs carry activity that it must override.
    task automatic do_reset();
        rst_i = 1'b1;
        set_alloc(2'b11, 1, 1);
        set_free(2'b11, 9, 10);
        afl_en = 1'b1;
        afl_data = '0;
        rcov_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        idle();
    endtask

    initial begin
        g_dbl_exp = (DblOn != 0) ? -1 : 0;
        //           act    a0 a1 fen    f0 f1 p0 p1 st cn
        vec[0]  = '{2'b00, 3, 4, 2'b00, 0, 0, 1, 2, 0, 63};
        vec[1]  = '{2'b11, 3, 4, 2'b00, 0, 0, 1, 2, 0, 63};
        vec[2]  = '{2'b11, 3, 4, 2'b00, 0, 0, 3, 4, 0, 63};
        vec[3]  = '{2'b11, 0, 5, 2'b00, 0, 0, 0, 6, 0, 61};
        vec[4]  = '{2'b00, 1, 1, 2'b00, 0, 0, 5, 7, 0, 59};
        vec[5]  = '{2'b11, 1, 1, 2'b01, 5, 0, 5, 7, 0, 58};
        vec[6]  = '{2'b00, 1, 1, 2'b00, 0, 0, 5, 8, 0, 58};
        vec[7]  = '{2'b00, 1, 1, 2'b11, 1, 2, 5, 8, 0, 57};
        vec[8]  = '{2'b00, 1, 1, 2'b00, 0, 0, 1, 2, 0, 57};
        vec[9]  = '{2'b00, 1, 1, 2'b01, 0, 0, 1, 2, 0, 59};
        vec[10] = '{2'b00, 1, 1, 2'b00, 3, 0, 1, 2, 0, 59};
        vec[11] = '{2'b00, 1, 1, 2'b00, 0, 0, 1, 2, 0, 59};
        vec[12] = '{2'b00, 1, 1, 2'b00, 0, 0, 1, 2, 0, 59};

        rst_i = 1'b1;
        idle();
        @(negedge clk);
        do_reset();

        for (int v = 0; v < 13; v++) begin
            set_alloc(vec[v].act, vec[v].arc0, vec[v].arc1);
            set_free(vec[v].fen, vec[v].f0, vec[v].f1);
            step($sformatf("vec%0d", v), vec[v].p0, vec[v].p1, vec[v].st, vec[v].cn);
        end

        // Fill until only index 63 remains, then stall and release back past the safe threshold.
        do_reset();
        for (int k = 0; k < 31; k++) begin
            set_alloc(2'b11, 1, 1);
            if (k == 29) safe = 1'b1;
            step($sformatf("fill%0d", k), 2 * k + 1, 2 * k + 2, 0, (k == 0) ? 63 : 65 - 2 * k);
        end
        set_alloc(2'b11, 1, 1);
        step("full0", 63, 0, 1, 3);
        set_alloc(2'b11, 1, 1);
        step("full1", 63, 0, 1, 1);
        set_alloc(2'b00, 1, 1); set_free(2'b11, 1, 2);
        step("full2", 63, 0, 1, 1);
        set_alloc(2'b00, 1, 1); set_free(2'b01, 3, 0);
        step("refill0", 1, 2, 0, 1);
        set_alloc(2'b00, 1, 1); set_free(2'b11, 4, 5);
        step("refill1", 1, 2, 0, 3);
        set_alloc(2'b00, 1, 1); safe = 1'b1;
        step("safe4", 1, 2, 1, 4);
        set_alloc(2'b00, 1, 1); safe = 1'b1;
        step("safe6", 1, 2, 0, 6);

        // Checkpoint save, release propagation into the image, then restore.
        do_reset();
        set_alloc(2'b11, 1, 1);
        step("ck0", 1, 2, 0, 63);
        set_alloc(2'b11, 1, 1); save_en = 1'b1; save_idx = 2'd2;
        step("ck1", 3, 4, 0, 63);
        set_alloc(2'b00, 1, 1); set_free(2'b01, 1, 0);
        step("ck2", 5, 6, 0, 61);
        set_alloc(2'b00, 1, 1); rcov_en = 1'b1; rcov_idx = 2'd2;
        step("ck3", 1, 5, 0, 59);
        set_alloc(2'b00, 1, 1);
        step("ck4", 1, 3, 0, 60);
        set_alloc(2'b00, 1, 1);
        step("ck5", 1, 3, 0, 62);

        // Architectural restore drops same-cycle allocations and releases.
        do_reset();
        set_alloc(2'b11, 1, 1); set_free(2'b01, 3, 0);
        afl_en = 1'b1; afl_data = 64'hFFFF_FFFF_0000_0001;
        step("afl0", 1, 2, 0, 63);
        set_alloc(2'b00, 1, 1);
        step("afl1", 32, 33, 0, 63);
        set_alloc(2'b00, 1, 1);
        step("afl2", 32, 33, 0, 32);

        // Same-slot save and restore, then afl priority over checkpoint restore.
        do_reset();
        set_alloc(2'b00, 1, 1); save_en = 1'b1; save_idx = 2'd1;
        step("ss0", 1, 2, 0, 63);
        set_alloc(2'b11, 1, 1);
        step("ss1", 1, 2, 0, 63);
        set_alloc(2'b11, 1, 1); save_en = 1'b1; save_idx = 2'd1;
        rcov_en = 1'b1; rcov_idx = 2'd1;
        step("ss2", 3, 4, 0, 63);
        set_alloc(2'b00, 1, 1);
        step("ss3", 1, 2, 0, 61);
        set_alloc(2'b00, 1, 1); rcov_en = 1'b1; rcov_idx = 2'd1;
        step("ss4", 1, 2, 0, 63);
        set_alloc(2'b00, 1, 1);
        step("ss5", 3, 4, 0, 63);
        set_alloc(2'b00, 1, 1); rcov_en = 1'b1; rcov_idx = 2'd1;
        afl_en = 1'b1; afl_data = '1;
        step("ss6", 3, 4, 0, 61);
        set_alloc(2'b00, 1, 1);
        step("ss7", 1, 2, 0, 61);

        // Double-free flag: sticky when built, tied low otherwise.
        do_reset();
        g_dbl_exp = 0;
        set_alloc(2'b00, 1, 1);
        step("df0", 1, 2, 0, 63);
        set_alloc(2'b00, 1, 1); set_free(2'b01, 7, 0);
        step("df1", 1, 2, 0, 63);
        g_dbl_exp = DblOn;
        set_alloc(2'b00, 1, 1);
        step("df2", 1, 2, 0, 63);
        set_alloc(2'b00, 1, 1);
        step("df3", 1, 2, 0, 63);
        do_reset();
        g_dbl_exp = 0;
        set_alloc(2'b00, 1, 1);
        step("df4", 1, 2, 0, 63);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
